ahb2aqu_n: RTL and testbench

Parametrised AHB-Lite slave bridge that fans one AHB port out to `NCE` Aquarius-style peripheral chip-enable channels. It replaces the fixed 4-channel, always-ready bridge.

- Peripherals may insert wait states through a per-channel `ack`.
- Unmapped addresses return a two-cycle AHB ERROR.
- An optional watchdog aborts a hung access.

The block sits between the AHB interconnect and the on-chip peripheral cluster.

---
 rtl/ahb2aqu_n_pkg.sv | 35 +++
 rtl/ahb2aqu_n_decode.sv | 38 +++
 rtl/ahb2aqu_n.sv | 201 ++++++++++++++++++++
 tb/tb_ahb2aqu_n.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2aqu_n_pkg.sv
// Shared definitions for the AHB-Lite to Aquarius chip-enable bridge:
// AHB transfer/response codes, the bridge state enum and the byte-lane helper.
package ahb2aqu_n_pkg;

    // AHB HTRANS encodings
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    // AHB HRESP encodings
    localparam logic [1:0] AHB_OKAY  = 2'b00;
    localparam logic [1:0] AHB_ERROR = 2'b01;

    typedef enum logic [1:0] {
        AQUN_IDLE   = 2'd0,
        AQUN_ACCESS = 2'd1,
        AQUN_ERR1   = 2'd2,
        AQUN_ERR2   = 2'd3
    } aqun_st_t;

    // Big-endian byte lanes: sel[3] is byte address 0. Oversized transfers
    // produce no lanes; the decoder flags them as unmapped.
    function automatic logic [3:0] aqun_sel(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b1000 >> a;
            3'd1:    lanes = a[1] ? 4'b0011 : 4'b1100;
            3'd2:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb2aqu_n_decode.sv
// Combinational address decoder: haddr/hsize -> one-hot channel enable,
// byte lanes and an unmapped flag (channel out of range or bad size).
module aqun_decode
    import ahb2aqu_n_pkg::*;
#(
    parameter int NCE     = 4,
    parameter int DEC_LSB = 8,
    parameter int DEC_W   = 8
) (
    input  logic [31:0]    haddr,
    input  logic [2:0]     hsize,
    output logic [NCE-1:0] ce,
    output logic [3:0]     sel,
    output logic           unmapped
);

    logic [DEC_W-1:0] field;
    logic [NCE-1:0]   hit;
    logic             size_ok;
    logic             unused_haddr;

    assign field        = haddr[DEC_LSB +: DEC_W];
    assign size_ok      = (hsize <= 3'd2);
    // Only the decode field and the low two bits matter here.
    assign unused_haddr = ^haddr;

    genvar gi;
    generate
        for (gi = 0; gi < NCE; gi++) begin : g_hit
            assign hit[gi] = (32'(field) == gi);
        end
    endgenerate

    assign ce       = size_ok ? hit : '0;
    assign sel      = aqun_sel(hsize, haddr[1:0]);
    assign unmapped = ~size_ok | ~(|hit);

endmodule

// File: rtl/ahb2aqu_n.sv
// AHB-Lite slave bridge fanning one AHB port out to NCE chip-enable channels
// with per-channel wait states (ack) and a two-cycle ERROR for unmapped
// addresses. Define AHB2AQU_TMO_EN to add a watchdog that aborts an access
// left without ack for TMO cycles.
module ahb2aqu_n
    import ahb2aqu_n_pkg::*;
#(
    parameter int NCE     = 4,
    parameter int DEC_LSB = 8,
    parameter int DEC_W   = 8,
    parameter int TMO     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready_in,
    output logic [31:0]       hrdata,
    output logic              hready_out,
    output logic [1:0]        hresp,
    output logic [NCE-1:0]    ce,
    output logic              stb,
    output logic [31:0]       adr,
    output logic              we,
    output logic [31:0]       wdata,
    output logic [3:0]        sel,
    input  logic [NCE*32-1:0] rdata,
    input  logic [NCE-1:0]    ack
);

    aqun_st_t       state_reg, state_next;
    logic [NCE-1:0] ce_reg, ce_next;
    logic           stb_reg, stb_next;
    logic [31:0]    adr_reg, adr_next;
    logic           we_reg, we_next;
    logic [3:0]     sel_reg, sel_next;

    logic [NCE-1:0] dec_ce;
    logic [3:0]     dec_sel;
    logic           dec_unmapped;
    logic           valid;
    logic           ack_hit;
    logic           capture;
    logic           start_access;
    logic [NCE-1:0][31:0] rd_gated;
    logic [31:0]    rd_or;

`ifdef AHB2AQU_TMO_EN
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TMO - 1);
    logic [CW-1:0]  cnt_reg, cnt_next;
`else
    logic           unused_tmo;
    assign unused_tmo = (TMO > 0);
`endif

    aqun_decode #(
        .NCE     (NCE),
        .DEC_LSB (DEC_LSB),
        .DEC_W   (DEC_W)
    ) u_decode (
        .haddr    (haddr),
        .hsize    (hsize),
        .ce       (dec_ce),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    assign valid   = hsel & ((htrans == AHB_NONSEQ) | (htrans == AHB_SEQ)) & hready_in;
    // Acks from channels other than the active one have no effect.
    assign ack_hit = |(ce_reg & ack);

    genvar gi;
    generate
        for (gi = 0; gi < NCE; gi++) begin : g_rd
            assign rd_gated[gi] = ce_reg[gi] ? rdata[gi*32 +: 32] : 32'd0;
        end
    endgenerate

    // OR-combine the gated channel read data (at most one channel enabled)
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NCE; i++) begin
            rd_or = rd_or | rd_gated[i];
        end
    end

    // Next-state, latched-field updates and AHB response outputs
    always_comb begin
        state_next   = state_reg;
        ce_next      = ce_reg;
        stb_next     = stb_reg;
        adr_next     = adr_reg;
        we_next      = we_reg;
        sel_next     = sel_reg;
        hready_out   = 1'b1;
        hresp        = AHB_OKAY;
        capture      = 1'b0;
        start_access = 1'b0;
`ifdef AHB2AQU_TMO_EN
        cnt_next     = cnt_reg;
`endif
        case (state_reg)
            AQUN_IDLE: begin
                capture = 1'b1;
            end
            AQUN_ACCESS: begin
                hready_out = ack_hit;
                if (ack_hit) begin
                    capture = 1'b1;
                end else begin
`ifdef AHB2AQU_TMO_EN
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_MAX) begin
                        state_next = AQUN_ERR1;
                        stb_next   = 1'b0;
                        ce_next    = '0;
                    end
`endif
                end
            end
            AQUN_ERR1: begin
                hresp      = AHB_ERROR;
                hready_out = 1'b0;
                state_next = AQUN_ERR2;
            end
            AQUN_ERR2: begin
                // The master cancels whatever it presents here.
                hresp      = AHB_ERROR;
                state_next = AQUN_IDLE;
            end
            default: begin
                state_next = AQUN_IDLE;
            end
        endcase

        // Address-phase capture: from IDLE, or at the end of an acked access
        if (capture) begin
            if (valid && !dec_unmapped) begin
                start_access = 1'b1;
                state_next   = AQUN_ACCESS;
                ce_next      = dec_ce;
                stb_next     = 1'b1;
                adr_next     = haddr;
                we_next      = hwrite;
                sel_next     = dec_sel;
            end else if (valid) begin
                state_next = AQUN_ERR1;
                stb_next   = 1'b0;
                ce_next    = '0;
            end else begin
                state_next = AQUN_IDLE;
                stb_next   = 1'b0;
                ce_next    = '0;
            end
        end
`ifdef AHB2AQU_TMO_EN
        if (start_access) begin
            cnt_next = '0;
        end
`endif
    end

    // State and latched-field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= AQUN_IDLE;
            ce_reg    <= '0;
            stb_reg   <= 1'b0;
            adr_reg   <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
`ifdef AHB2AQU_TMO_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ce_reg    <= ce_next;
            stb_reg   <= stb_next;
            adr_reg   <= adr_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
`ifdef AHB2AQU_TMO_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    assign hrdata = (state_reg == AQUN_ACCESS) ? rd_or : 32'd0;
    assign ce     = ce_reg;
    assign stb    = stb_reg;
    assign adr    = adr_reg;
    assign we     = we_reg;
    assign sel    = sel_reg;
    assign wdata  = hwdata;

endmodule

// File: tb/tb_ahb2aqu_n.sv
// Self-checking bench for ahb2aqu_n: a table of directed transfers, random
// transfers checked against a transaction-level model, and hand-written
// sequences for back-to-back, stall/timeout and mid-access reset.
module tb_ahb2aqu_n;

    localparam int NCE = 4;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              hready_in;
    logic [31:0]       hrdata;
    logic              hready_out;
    logic [1:0]        hresp;
    logic [NCE-1:0]    ce;
    logic              stb;
    logic [31:0]       adr;
    logic              we;
    logic [31:0]       wdata;
    logic [3:0]        sel;
    logic [NCE*32-1:0] rdata;
    logic [NCE-1:0]    ack;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Single-slave system: the bus HREADY is this slave's own HREADYOUT.
    assign hready_in = hready_out;

    ahb2aqu_n #(.NCE(NCE), .DEC_LSB(8), .DEC_W(8), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
        .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp), .ce(ce),
        .stb(stb), .adr(adr), .we(we), .wdata(wdata), .sel(sel),
        .rdata(rdata), .ack(ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        int          waits;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  e_ce;
        logic [3:0]  e_sel;
        logic        e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the decode field picks the channel; lanes follow
    // big-endian byte numbering of the addressed bytes.
    function automatic vec_t model(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                                   input int k, input logic [31:0] rd, input logic [31:0] wd);
        vec_t v;
        int ch;
        int first, nbytes;
        v.addr = a; v.size = sz; v.wr = wr; v.waits = k; v.rd = rd; v.wd = wd;
        ch = int'((a >> 8) & 32'hFF);
        v.e_err = (ch >= NCE) || (sz > 3'd2);
        v.e_ce  = v.e_err ? 4'd0 : 4'(1 << ch);
        nbytes  = 1 << int'(sz > 3'd2 ? 3'd0 : sz);
        first   = int'(a[1:0]) & ~(nbytes - 1);
        v.e_sel = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= first && b < first + nbytes) v.e_sel[3 - b] = 1'b1;
        end
        return v;
    endfunction

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    endtask

    // One transfer, entered just after a negedge with the DUT idle
    task automatic xfer(input vec_t v);
        int ch;
        logic [3:0] noise;
        ch = int'((v.addr >> 8) & 32'hFF);
        hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hsize = v.size; hwrite = v.wr;
        @(negedge clk);
        idle_bus();
        hwdata = v.wd;
        if (!v.e_err) begin
            rdata = {$urandom, $urandom, $urandom, $urandom};
            rdata[ch*32 +: 32] = v.rd;
            for (int c = 0; c <= v.waits; c++) begin
                noise = 4'($urandom) & ~v.e_ce;
                ack = (c == v.waits) ? (v.e_ce | noise) : noise;
                #1;
                if (c == 0) begin
                    chk("ce", 32'(ce), 32'(v.e_ce));
                    chk("sel", 32'(sel), 32'(v.e_sel));
                    chk("we", 32'(we), 32'(v.wr));
                    chk("adr", adr, v.addr);
                end
                chk("stb_held", 32'(stb), 32'd1);
                chk("hready_phase", 32'(hready_out), (c == v.waits) ? 32'd1 : 32'd0);
                chk("hresp_ok", 32'(hresp), 32'd0);
                if (c == v.waits) begin
                    if (!v.wr) chk("hrdata", hrdata, v.rd);
                    else       chk("wdata", wdata, v.wd);
                end
                @(negedge clk);
            end
            ack = '0;
            #1;
            chk("stb_end", 32'(stb), 32'd0);
            chk("ce_end", 32'(ce), 32'd0);
            chk("hrdata_idle", hrdata, 32'd0);
        end else begin
            #1;
            chk("err1_hresp", 32'(hresp), 32'd1);
            chk("err1_hready", 32'(hready_out), 32'd0);
            chk("err1_stb", 32'(stb), 32'd0);
            @(negedge clk);
            #1;
            chk("err2_hresp", 32'(hresp), 32'd1);
            chk("err2_hready", 32'(hready_out), 32'd1);
            chk("err2_stb", 32'(stb), 32'd0);
            @(negedge clk);
            #1;
            chk("post_err_hresp", 32'(hresp), 32'd0);
            chk("post_err_hready", 32'(hready_out), 32'd1);
        end
    endtask

    vec_t tbl[7];

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int lows;
        tbl[0] = '{32'h0000_0200, 3'd2, 1'b0, 0, 32'hDEADBEEF, 32'h0, 4'b0100, 4'b1111, 1'b0};
        tbl[1] = '{32'h0000_0103, 3'd0, 1'b1, 3, 32'h0, 32'hA5A5_0011, 4'b0010, 4'b0001, 1'b0};
        tbl[2] = '{32'h0000_0002, 3'd1, 1'b0, 1, 32'h1234_5678, 32'h0, 4'b0001, 4'b0011, 1'b0};
        tbl[3] = '{32'h0000_0500, 3'd2, 1'b0, 0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b1};
        tbl[4] = '{32'h0000_0301, 3'd0, 1'b1, 2, 32'h0, 32'hCAFE_F00D, 4'b1000, 4'b0100, 1'b0};
        tbl[5] = '{32'h0000_0100, 3'd3, 1'b0, 0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b1};
        tbl[6] = '{32'h1234_0300, 3'd1, 1'b0, 0, 32'h0BAD_CAFE, 32'h0, 4'b1000, 4'b1100, 1'b0};

        rst = 1'b1; idle_bus(); hwdata = '0; rdata = '0; ack = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_hready", 32'(hready_out), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven directed transfers
        for (int i = 0; i < 7; i++) begin
            xfer(tbl[i]);
            $display("table vec %0d addr=%h size=%0d wr=%0d waits=%0d err=%0d", i,
                     tbl[i].addr, tbl[i].size, tbl[i].wr, tbl[i].waits, tbl[i].e_err);
        end

        // BUSY and IDLE transfers are ignored with a zero-wait OKAY
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_0100; hsize = 3'd2;
        #1;
        chk("busy_hready", 32'(hready_out), 32'd1);
        @(negedge clk);
        #1;
        chk("busy_stb", 32'(stb), 32'd0);
        idle_bus();
        @(negedge clk);
        $display("busy transfer ignored");

        // Randomised transfers against the model
        for (int i = 0; i < 40; i++) begin
            v = model({16'($urandom), 8'($urandom_range(0, 5)), 8'($urandom)},
                      3'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 4)),
                      $urandom, $urandom);
            xfer(v);
            $display("rand vec %0d addr=%h size=%0d wr=%0d waits=%0d err=%0d", i,
                     v.addr, v.size, v.wr, v.waits, v.e_err);
        end

        // Back-to-back zero-wait NONSEQ to ch0 then ch3
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0000; hsize = 3'd2; hwrite = 1'b0;
        @(negedge clk);
        ack = 4'b0001;
        haddr = 32'h0000_0300;
        #1;
        chk("b2b_ce0", 32'(ce), 32'h1);
        chk("b2b_hready0", 32'(hready_out), 32'd1);
        @(negedge clk);
        idle_bus();
        ack = 4'b1000;
        #1;
        chk("b2b_ce3", 32'(ce), 32'h8);
        chk("b2b_stb3", 32'(stb), 32'd1);
        @(negedge clk);
        ack = '0;
        #1;
        chk("b2b_end_stb", 32'(stb), 32'd0);
        $display("back-to-back ch0 -> ch3 done");

        // An access left without ack
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0100; hsize = 3'd2; hwrite = 1'b0;
        @(negedge clk);
        idle_bus();
        ack = 4'b1101;
        lows = 0;
`ifdef AHB2AQU_TMO_EN
        for (int c = 0; c < 40 && stb; c++) begin
            lows++;
            @(negedge clk);
        end
        #1;
        chk("tmo_stb_cycles", 32'(lows), 32'(TMO));
        chk("tmo_err1_hresp", 32'(hresp), 32'd1);
        chk("tmo_err1_hready", 32'(hready_out), 32'd0);
        chk("tmo_ce", 32'(ce), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo_err2_hresp", 32'(hresp), 32'd1);
        chk("tmo_err2_hready", 32'(hready_out), 32'd1);
        @(negedge clk);
        ack = '0;
        $display("watchdog abort after %0d strobe cycles", lows);
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!hready_out && stb) lows++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(lows), 32'd20);
        ack = 4'b0010;
        #1;
        chk("stall_release", 32'(hready_out), 32'd1);
        @(negedge clk);
        ack = '0;
        $display("stall held %0d cycles until ack", lows);
`endif

        // Reset during a waited access
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0200; hsize = 3'd2; hwrite = 1'b1;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        #1;
        chk("pre_rst_stb", 32'(stb), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_stb", 32'(stb), 32'd0);
        chk("mid_rst_ce", 32'(ce), 32'd0);
        chk("mid_rst_hready", 32'(hready_out), 32'd1);
        chk("mid_rst_hresp", 32'(hresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("reset during access done");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
